// File: rtl/apb_slave_regs.sv
// APB slave with NUM_REGS byte registers and a read-only ID at 4'hF.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES access-phase wait states.
module apb_slave_regs #(
   parameter int         NUM_REGS    = 12,
   parameter int         WAIT_CYCLES = 2,
   parameter logic [7:0] ID_VALUE    = 8'h5A
) (
   input  logic       pclk,
   input  logic       prst,
   input  logic [3:0] paddr,
   input  logic [7:0] pwdata,
   input  logic       pwrite,
   input  logic       psel,
   input  logic       penable,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr
);

   if (NUM_REGS < 1 || NUM_REGS > 15 ||
       WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_cfg_err
      $error("apb_slave_regs: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   localparam logic [4:0] NREG = 5'(NUM_REGS);

   state_e     state_q, state_d;
   logic [3:0] addr_q, addr_d;
   logic       wr_q, wr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] prdata_q, prdata_d;
   logic       pready_q, pready_d;
   logic       pslverr_q, pslverr_d;
   logic [7:0] regs_q [16];

   logic       setup, set_done, commit;
   logic [3:0] sel_addr;
   logic       sel_wr;
   logic [7:0] rd_val;
   logic       err;

`ifdef APB_SLV_WAIT_EN
   localparam logic [2:0] WCNT = 3'(WAIT_CYCLES);
   logic [2:0] cnt_q, cnt_d;
`endif

   assign setup = psel & ~penable;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      set_done = 1'b0;
`ifdef APB_SLV_WAIT_EN
      cnt_d    = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               addr_d  = paddr;
               wr_d    = pwrite;
               wdata_d = pwdata;
`ifdef APB_SLV_WAIT_EN
               if (WCNT == 3'd0) begin
                  state_d  = DONE;
                  set_done = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WCNT;
               end
`else
               state_d  = DONE;
               set_done = 1'b1;
`endif
            end
         end
         WAIT: begin
`ifdef APB_SLV_WAIT_EN
            // Master dropping psel mid-wait aborts the transfer.
            if (!psel) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else if (penable) begin
               if (cnt_q == 3'd1) begin
                  state_d  = DONE;
                  set_done = 1'b1;
                  cnt_d    = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
`else
            state_d = IDLE;
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Zero-wait completes on the setup edge, so decode from the live bus then.
   assign sel_addr = (state_q == IDLE) ? paddr  : addr_q;
   assign sel_wr   = (state_q == IDLE) ? pwrite : wr_q;

   always_comb begin
      rd_val = 8'h00;
      err    = 1'b0;
      if (sel_addr == 4'hF) begin
         rd_val = ID_VALUE;
         err    = sel_wr;
      end else if ({1'b0, sel_addr} < NREG) begin
         rd_val = regs_q[sel_addr];
      end else begin
         err = 1'b1;
      end
   end

   always_comb begin
      pready_d  = set_done;
      pslverr_d = set_done & err;
      prdata_d  = (set_done & ~sel_wr) ? rd_val : prdata_q;
   end

   assign commit = (state_q == DONE) & wr_q & ({1'b0, addr_q} < NREG);

   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         state_q   <= IDLE;
         addr_q    <= 4'h0;
         wr_q      <= 1'b0;
         wdata_q   <= 8'h00;
         prdata_q  <= 8'h00;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
         cnt_q     <= 3'd0;
`endif
         for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         prdata_q  <= prdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
         cnt_q     <= cnt_d;
`endif
         if (commit) regs_q[addr_q] <= wdata_q;
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench for apb_slave_regs; latency expectation follows
// whether APB_SLV_WAIT_EN is defined for the build.
module tb_apb_slave_regs;

   localparam int         NUM = 12;
   localparam int         WC  = 2;
   localparam logic [7:0] ID  = 8'h5A;
`ifdef APB_SLV_WAIT_EN
   localparam int EXP_LAT = WC + 1;
`else
   localparam int EXP_LAT = 1;
`endif

   logic       pclk = 1'b0;
   logic       prst = 1'b0;
   logic [3:0] paddr = 4'h0;
   logic [7:0] pwdata = 8'h00;
   logic       pwrite = 1'b0;
   logic       psel = 1'b0;
   logic       penable = 1'b0;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      logic [7:0] rd;
      logic       er;
      logic       chk_rd;
      string      tag;
   } exp_t;

   typedef struct {
      logic       got;
      int         lat;
      logic [7:0] rd;
      logic       er;
      logic       after;
   } res_t;

   exp_t       exp_q[$];
   res_t       res_q[$];
   logic [7:0] model [16];

   apb_slave_regs #(
      .NUM_REGS(NUM), .WAIT_CYCLES(WC), .ID_VALUE(ID)
   ) dut (
      .pclk(pclk), .prst(prst), .paddr(paddr), .pwdata(pwdata),
      .pwrite(pwrite), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   function automatic void push_exp(input logic [3:0] a, input logic w,
                                    input logic [7:0] d, input string tag);
      exp_t e;
      e.tag = tag;
      e.chk_rd = ~w;
      e.rd = 8'h00;
      if (w) begin
         e.er = (a == 4'hF) || (int'(a) >= NUM);
         if (int'(a) < NUM) model[a] = d;
      end else begin
         e.er = (a != 4'hF) && (int'(a) >= NUM);
         if (a == 4'hF) e.rd = ID;
         else if (int'(a) < NUM) e.rd = model[a];
      end
      exp_q.push_back(e);
   endfunction

   // Entered and left at edge+1; a following call is a back-to-back setup.
   task automatic xfer(input logic [3:0] a, input logic w, input logic [7:0] d,
                       input int drop_at, output res_t r);
      r.got = 1'b0; r.lat = 0; r.rd = 8'h00; r.er = 1'b0; r.after = 1'b0;
      paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         if (pready) begin
            r.got = 1'b1; r.lat = c; r.rd = prdata; r.er = pslverr;
            break;
         end
         if (c == drop_at) break;
         @(posedge pclk); #1;
      end
      if (r.got) begin
         @(posedge pclk); #1;
         r.after = pready;
         psel = 1'b0; penable = 1'b0;
      end else begin
         psel = 1'b0; penable = 1'b0;
         repeat (4) begin
            @(posedge pclk); #1;
            if (pready) r.got = 1'b1;
         end
      end
   endtask

   task automatic run_op(input logic [3:0] a, input logic w, input logic [7:0] d,
                         input string tag, input bit b2b);
      res_t r;
      push_exp(a, w, d, tag);
      xfer(a, w, d, 0, r);
      res_q.push_back(r);
      if (!b2b) begin
         @(posedge pclk); #1;
      end
   endtask

   task automatic test_reset;
      prst = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      repeat (2) @(posedge pclk);
      #1;
      n_cmp++; if (pready !== 1'b0) begin n_mis++; $display("FAIL rst_pready: got %b want 0", pready); end
      n_cmp++; if (pslverr !== 1'b0) begin n_mis++; $display("FAIL rst_pslverr: got %b want 0", pslverr); end
      n_cmp++; if (prdata !== 8'h00) begin n_mis++; $display("FAIL rst_prdata: got %h want 00", prdata); end
      prst = 1'b1;
   endtask

   task automatic test_write_read;
      exp_t e; res_t r;
      run_op(4'h2, 1'b1, 8'h3C, "wr2", 1'b0);
      run_op(4'h2, 1'b0, 8'h00, "rd2", 1'b0);
      run_op(4'hB, 1'b1, 8'hC5, "wr11", 1'b0);
      run_op(4'hB, 1'b0, 8'h00, "rd11", 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); r = res_q.pop_front();
         n_cmp++; if (r.got !== 1'b1 || r.lat != EXP_LAT) begin n_mis++; $display("FAIL %s lat: got rdy=%b lat=%0d want lat=%0d", e.tag, r.got, r.lat, EXP_LAT); end
         n_cmp++; if (r.er !== e.er) begin n_mis++; $display("FAIL %s err: got %b want %b", e.tag, r.er, e.er); end
         if (e.chk_rd) begin n_cmp++; if (r.rd !== e.rd) begin n_mis++; $display("FAIL %s rdata: got %h want %h", e.tag, r.rd, e.rd); end end
         n_cmp++; if (r.after !== 1'b0) begin n_mis++; $display("FAIL %s one_cycle: pready got %b want 0", e.tag, r.after); end
      end
   endtask

   task automatic test_id_and_range;
      exp_t e; res_t r;
      run_op(4'hF, 1'b0, 8'h00, "rdid", 1'b0);
      run_op(4'hF, 1'b1, 8'hFF, "wrid", 1'b0);
      run_op(4'hF, 1'b0, 8'h00, "rdid2", 1'b0);
      run_op(4'hC, 1'b1, 8'h11, "wr12", 1'b0);
      run_op(4'hC, 1'b0, 8'h00, "rd12", 1'b0);
      run_op(4'hE, 1'b0, 8'h00, "rd14", 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); r = res_q.pop_front();
         n_cmp++; if (r.got !== 1'b1 || r.lat != EXP_LAT) begin n_mis++; $display("FAIL %s lat: got rdy=%b lat=%0d want lat=%0d", e.tag, r.got, r.lat, EXP_LAT); end
         n_cmp++; if (r.er !== e.er) begin n_mis++; $display("FAIL %s err: got %b want %b", e.tag, r.er, e.er); end
         if (e.chk_rd) begin n_cmp++; if (r.rd !== e.rd) begin n_mis++; $display("FAIL %s rdata: got %h want %h", e.tag, r.rd, e.rd); end end
      end
   endtask

   task automatic test_penable_only;
      exp_t e; res_t r;
      logic seen;
      seen = 1'b0;
      paddr = 4'h3; pwrite = 1'b1; pwdata = 8'hAA; psel = 1'b1; penable = 1'b1;
      repeat (3) begin
         @(posedge pclk); #1;
         if (pready) seen = 1'b1;
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      n_cmp++; if (seen !== 1'b0) begin n_mis++; $display("FAIL penable_only: pready got %b want 0", seen); end
      run_op(4'h3, 1'b0, 8'h00, "rd3", 1'b0);
      e = exp_q.pop_front(); r = res_q.pop_front();
      n_cmp++; if (r.rd !== e.rd) begin n_mis++; $display("FAIL %s rdata: got %h want %h", e.tag, r.rd, e.rd); end
   endtask

   task automatic test_back_to_back;
      exp_t e; res_t r;
      logic [3:0] av [6];
      av = '{4'h0, 4'h3, 4'h7, 4'hB, 4'hD, 4'hF};
      for (int i = 0; i < 6; i++) run_op(av[i], 1'b1, 8'($urandom), "b2b_wr", 1'b1);
      for (int i = 0; i < 6; i++) run_op(av[i], 1'b0, 8'h00, "b2b_rd", 1'b1);
      @(posedge pclk); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); r = res_q.pop_front();
         n_cmp++; if (r.got !== 1'b1 || r.lat != EXP_LAT) begin n_mis++; $display("FAIL %s lat: got rdy=%b lat=%0d want lat=%0d", e.tag, r.got, r.lat, EXP_LAT); end
         n_cmp++; if (r.er !== e.er) begin n_mis++; $display("FAIL %s err: got %b want %b", e.tag, r.er, e.er); end
         if (e.chk_rd) begin n_cmp++; if (r.rd !== e.rd) begin n_mis++; $display("FAIL %s rdata: got %h want %h", e.tag, r.rd, e.rd); end end
      end
   endtask

`ifdef APB_SLV_WAIT_EN
   task automatic test_abort;
      exp_t e; res_t r;
      logic [7:0] held;
      run_op(4'h2, 1'b0, 8'h00, "pre_abort", 1'b0);
      void'(exp_q.pop_front()); void'(res_q.pop_front());
      held = prdata;
      xfer(4'h5, 1'b1, 8'h77, 1, r);
      n_cmp++; if (r.got !== 1'b0) begin n_mis++; $display("FAIL abort_ready: got %b want 0", r.got); end
      n_cmp++; if (prdata !== held) begin n_mis++; $display("FAIL abort_prdata: got %h want %h", prdata, held); end
      run_op(4'h5, 1'b0, 8'h00, "rd5", 1'b0);
      e = exp_q.pop_front(); r = res_q.pop_front();
      n_cmp++; if (r.rd !== e.rd) begin n_mis++; $display("FAIL %s rdata: got %h want %h", e.tag, r.rd, e.rd); end
   endtask
`endif

   task automatic test_reset_mid;
      exp_t e; res_t r;
      run_op(4'h2, 1'b0, 8'h00, "pre_rst", 1'b0);
      void'(exp_q.pop_front()); void'(res_q.pop_front());
      paddr = 4'h1; pwrite = 1'b1; pwdata = 8'h99; psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      #2 prst = 1'b0;
      #1;
      n_cmp++; if (pready !== 1'b0) begin n_mis++; $display("FAIL midrst_pready: got %b want 0", pready); end
      n_cmp++; if (pslverr !== 1'b0) begin n_mis++; $display("FAIL midrst_pslverr: got %b want 0", pslverr); end
      n_cmp++; if (prdata !== 8'h00) begin n_mis++; $display("FAIL midrst_prdata: got %h want 00", prdata); end
      psel = 1'b0; penable = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      @(posedge pclk); #1;
      prst = 1'b1;
      @(posedge pclk); #1;
      run_op(4'h1, 1'b0, 8'h00, "rd1", 1'b0);
      run_op(4'h2, 1'b0, 8'h00, "rd2_post", 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); r = res_q.pop_front();
         n_cmp++; if (r.rd !== e.rd) begin n_mis++; $display("FAIL %s rdata: got %h want %h", e.tag, r.rd, e.rd); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_id_and_range();
      test_penable_only();
      test_back_to_back();
`ifdef APB_SLV_WAIT_EN
      test_abort();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 12, number of read/write registers at addresses 0..NUM_REGS-1 (legal range 1..15).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, number of access-phase wait cycles inserted when APB_SLV_WAIT_EN is defined (legal range 0..7).
REQ-003 The block SHALL have parameter ID_VALUE, default 8'h5A, read-only value returned at address 4'hF.
REQ-004 pclk  input  1  sole clock; all state changes on its rising edge.
REQ-005 prst  input  1  asynchronous, active-low reset.
REQ-006 paddr  input  4  APB address from master.
REQ-007 pwdata  input  8  APB write data.
REQ-008 pwrite  input  1  1 = write transfer, 0 = read transfer.
REQ-009 psel  input  1  slave select.
REQ-010 penable  input  1  access-phase strobe.
REQ-011 prdata  output  8  registered read data.
REQ-012 pready  output  1  registered transfer-complete strobe.
REQ-013 pslverr  output  1  registered error response, valid only while pready=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-015 IDLE SHALL detect the setup phase as psel=1 and penable=0, and SHALL latch paddr, pwrite and pwdata on that edge.
REQ-016 On setup detection, the FSM SHALL go to DONE with pready=1 in the first access cycle when the wait count is 0; otherwise it SHALL load the wait counter and go to WAIT.
REQ-017 WAIT SHALL decrement the counter each cycle in which psel=1 and penable=1; when the counter reaches 1, the next state SHALL be DONE with pready=1.
REQ-018 pready SHALL be high for exactly one cycle per transfer; prdata and pslverr SHALL be valid in that same cycle.
REQ-019 The write SHALL commit on the edge ending the pready=1 cycle, using the data latched at setup.
REQ-020 A read SHALL load prdata from the register addressed at setup when pready is set, and SHALL hold prdata until the next read completes.
REQ-021 After DONE the FSM SHALL return to IDLE, and SHALL accept a back-to-back setup phase in the cycle that follows the pready=1 cycle.
REQ-022 Address 4'hF SHALL read as ID_VALUE with pslverr=0.
REQ-023 A write to 4'hF SHALL be dropped and SHALL return pslverr=1.
REQ-024 Any address from NUM_REGS to 4'hE SHALL return pslverr=1 and prdata=8'h00, with no register modified.
REQ-025 If psel falls before pready is asserted, the transfer SHALL abort: return to IDLE, no write, pready stays 0, prdata unchanged.
REQ-026 penable=1 while in IDLE with no prior setup phase SHALL be ignored.

Reset
REQ-027 When prst=0, the block SHALL immediately force the state to IDLE, the wait counter to 0, pready=0, pslverr=0, prdata=8'h00 and every register to 8'h00.
REQ-028 Reset asserted mid-transfer SHALL discard the transfer with no write committed.
REQ-029 After prst rises, the first setup phase SHALL be accepted on the first rising edge of pclk.

Configuration
REQ-030 Macro APB_SLV_WAIT_EN: when defined, the wait count SHALL be WAIT_CYCLES; when undefined, the wait count SHALL be 0 (zero-wait, pready in the first access cycle) and the WAIT state and counter logic SHALL be compiled out.

Verification
REQ-031 The bench SHALL cover: macro off, write 8'h3C to addr 2 then read addr 2 -> each pready in the first access cycle; prdata=8'h3C; pslverr=0.
REQ-032 The bench SHALL cover: macro on with WAIT_CYCLES=2, read addr 2 -> pready in the 3rd access cycle; prdata=8'h3C.
REQ-033 The bench SHALL cover: read addr 4'hF -> prdata=8'h5A, pslverr=0; write 8'hFF to 4'hF then read it -> first pslverr=1, second read still 8'h5A.
REQ-034 The bench SHALL cover: NUM_REGS=12, write 8'h11 to addr 4'hC -> pslverr=1; a read of addr 4'hC -> pslverr=1, prdata=8'h00.
REQ-035 The bench SHALL cover: macro on, write 8'h77 to addr 5 with psel dropped during WAIT -> no pready; a later read of addr 5 returns 8'h00.
REQ-036 The bench SHALL cover: prst=0 pulsed mid-write to addr 1 -> outputs 0 immediately; a later read of addr 1 returns 8'h00.
